led_blink_sched: RTL and testbench
==================================

LED_BLINK_SCHED -- requirements
Module: led_blink_sched

Interface
REQ-001 Parameter CBITS, default 11, prescaler width; one tick every 2^CBITS clk cycles.
REQ-002 Parameter ON_TICKS, default 2, ticks LED is high per blink (range 1..15).
REQ-003 Parameter OFF_TICKS, default 2, ticks LED is low between blinks (range 1..15).
REQ-004 Parameter GAP_TICKS, default 4, ticks LED is low after a service's last blink (range 1..15).
REQ-005 clk  input  1  clock, rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 req  input  4  per-requester level request; bit i = requester i.
REQ-008 req_cnt  input  12  blink counts, 3 bits per requester; requester i uses bits [3i+2:3i].
REQ-009 grant  output  4  one-hot (or zero) registered grant.
REQ-010 done  output  1  one-cycle pulse, final cycle of a service.
REQ-011 led  output  1  shared LED drive.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 flg  output  1  one-cycle pulse on every tick.

Function
REQ-014 Prescaler SHALL free-run modulo 2^CBITS from reset; tick = prescaler all-ones; flg SHALL be registered tick, i.e. high the cycle after prescaler is all-ones.
REQ-015 States SHALL be IDLE, ON, OFF, GAP.
REQ-016 IDLE: when any req bit is high, grant SHALL select one requester round-robin, starting from index (last_granted+1) mod 4, pointer 0 after reset; grant registered next cycle.
REQ-017 On grant, the selected req_cnt field SHALL be latched; later req_cnt changes SHALL NOT affect the service.
REQ-018 Latched count N>0: next state ON; N=0: next state GAP with no blinks.
REQ-019 ON: led=1; after ON_TICKS ticks, decrement remaining count; if remaining becomes 0 go to GAP, else OFF.
REQ-020 OFF: led=0; after OFF_TICKS ticks go to ON.
REQ-021 GAP: led=0; on the cycle GAP_TICKS ticks have elapsed, done=1 with grant still asserted; next cycle grant=0, state IDLE.
REQ-022 Tick counting in ON/OFF/GAP SHALL count only tick cycles; the first period after entering ON from IDLE may be partial.
REQ-023 grant SHALL stay constant for the entire service; dropping req mid-service SHALL NOT abort it; done still pulses.
REQ-024 A requester holding req after done is eligible again only in rotation order.
REQ-025 led SHALL be 0 in IDLE and GAP; led and grant change only on clk edges (no glitches).
REQ-026 Ticks arriving in IDLE SHALL be ignored; arbitration does not wait for a tick.

Reset
REQ-027 rst high SHALL immediately force state IDLE, grant=0, done=0, led=0, busy=0, flg=0, prescaler=0, RR pointer=0, latched count=0.
REQ-028 rst asserted mid-service SHALL abandon the service without a done pulse; after release, arbitration restarts from pointer 0.

Verification (bench uses CBITS=2, ON_TICKS=2, OFF_TICKS=2, GAP_TICKS=4)
REQ-029 Reset then idle 20 cycles, req=0 -> led=0, grant=0, busy=0, flg pulses every 4 cycles.
REQ-030 req=4'b0001, req_cnt[2:0]=3 -> grant=0001, exactly 3 led high pulses each 2 ticks long, GAP of 4 ticks, one done pulse, then grant=0.
REQ-031 req=4'b1111 held, all counts 1 -> grants in order 0001,0010,0100,1000,0001, each service one blink and one done.
REQ-032 req=4'b0100 with req_cnt[8:6]=0 -> grant=0100, no led pulse, done after 4 ticks.
REQ-033 During requester-1 service change req_cnt[5:3] from 2 to 7 and drop req[1] -> still exactly 2 blinks and done.
REQ-034 Assert rst during second blink of a 5-blink service -> led=0, grant=0, busy=0 same cycle, no done; after release req=4'b0010 is granted 0010.

Source files
------------

// File: rtl/led_blink_sched.sv
// Shared-LED blink scheduler: four requesters take turns on one LED.
// Each granted requester gets N blinks (N latched at grant time),
// followed by a fixed low gap, then the arbiter moves on round-robin.
// All timing is in prescaler ticks, one tick every 2^CBITS clocks.
module led_blink_sched #(
    parameter int CBITS     = 11,
    parameter int ON_TICKS  = 2,
    parameter int OFF_TICKS = 2,
    parameter int GAP_TICKS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [11:0] req_cnt,
    output logic [3:0]  grant,
    output logic        done,
    output logic        led,
    output logic        busy,
    output logic        flg
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    localparam logic [3:0] ON_LAST  = 4'(ON_TICKS - 1);
    localparam logic [3:0] OFF_LAST = 4'(OFF_TICKS - 1);
    localparam logic [3:0] GAP_LAST = 4'(GAP_TICKS - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [CBITS-1:0] r_presc;
    logic             w_tick;
    logic             r_flg;
    logic [3:0]       r_grant;
    logic [3:0]       w_grant_next;
    logic [1:0]       r_ptr;
    logic [1:0]       w_ptr_next;
    logic [2:0]       r_cnt;
    logic [2:0]       w_cnt_next;
    logic [3:0]       r_tcnt;
    logic [3:0]       w_tcnt_next;
    logic             r_led;
    logic             r_busy;
    logic             w_done;
    logic [3:0]       w_rot;
    logic [1:0]       w_off;
    logic [1:0]       w_winner;
    logic [2:0]       w_field [4];

    assign w_tick = &r_presc;

    // Requests rotated so that bit 0 is the requester the pointer favours,
    // plus each requester's blink-count field split out.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_req
            assign w_rot[gi]   = req[2'(gi) + r_ptr];
            assign w_field[gi] = req_cnt[3*gi +: 3];
        end
    endgenerate

    // Lowest set bit of the rotated request picks the round-robin winner.
    always_comb begin
        w_off = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (w_rot[k]) w_off = 2'(k);
        end
        w_winner = r_ptr + w_off;
    end

    // Next-state logic: arbitration in IDLE, tick counting in ON/OFF/GAP.
    always_comb begin
        w_state_next = r_state;
        w_grant_next = r_grant;
        w_ptr_next   = r_ptr;
        w_cnt_next   = r_cnt;
        w_tcnt_next  = r_tcnt;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Ticks are ignored here; a request is served straight away.
                if (|req) begin
                    w_grant_next = 4'b0001 << w_winner;
                    w_ptr_next   = w_winner + 2'd1;
                    w_cnt_next   = w_field[w_winner];
                    w_tcnt_next  = 4'd0;
                    if (w_field[w_winner] != 3'd0) w_state_next = ST_ON;
                    else                           w_state_next = ST_GAP;
                end
            end
            ST_ON: begin
                if (w_tick) begin
                    if (r_tcnt == ON_LAST) begin
                        w_tcnt_next = 4'd0;
                        w_cnt_next  = r_cnt - 3'd1;
                        if (r_cnt == 3'd1) w_state_next = ST_GAP;
                        else               w_state_next = ST_OFF;
                    end else begin
                        w_tcnt_next = r_tcnt + 4'd1;
                    end
                end
            end
            ST_OFF: begin
                if (w_tick) begin
                    if (r_tcnt == OFF_LAST) begin
                        w_tcnt_next  = 4'd0;
                        w_state_next = ST_ON;
                    end else begin
                        w_tcnt_next = r_tcnt + 4'd1;
                    end
                end
            end
            ST_GAP: begin
                if (w_tick) begin
                    if (r_tcnt == GAP_LAST) begin
                        // Last cycle of the service: grant is still held here.
                        w_done       = 1'b1;
                        w_tcnt_next  = 4'd0;
                        w_grant_next = 4'd0;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_tcnt_next = r_tcnt + 4'd1;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State, prescaler and registered outputs; reset abandons any service.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_presc <= '0;
            r_flg   <= 1'b0;
            r_grant <= 4'd0;
            r_ptr   <= 2'd0;
            r_cnt   <= 3'd0;
            r_tcnt  <= 4'd0;
            r_led   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_presc <= r_presc + 1'b1;
            r_flg   <= w_tick;
            r_grant <= w_grant_next;
            r_ptr   <= w_ptr_next;
            r_cnt   <= w_cnt_next;
            r_tcnt  <= w_tcnt_next;
            r_led   <= (w_state_next == ST_ON);
            r_busy  <= (w_state_next != ST_IDLE);
        end
    end

    assign grant = r_grant;
    assign done  = w_done;
    assign led   = r_led;
    assign busy  = r_busy;
    assign flg   = r_flg;

endmodule

// File: tb/tb_led_blink_sched.sv
// Directed bench for led_blink_sched with a 4-cycle tick (CBITS=2).
// A local prescaler model supplies tick timing; each scenario task
// drives its stimulus and compares what it saw with hand-derived values.
module tb_led_blink_sched;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [11:0] req_cnt;
    logic [3:0]  grant;
    logic        done;
    logic        led;
    logic        busy;
    logic        flg;

    int errors = 0;
    int checks = 0;

    led_blink_sched #(
        .CBITS(2), .ON_TICKS(2), .OFF_TICKS(2), .GAP_TICKS(4)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_cnt(req_cnt),
        .grant(grant), .done(done), .led(led), .busy(busy), .flg(flg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference prescaler: a tick is any cycle where it reads 3.
    logic [1:0] m_presc;
    always @(posedge clk or posedge rst) begin
        if (rst) m_presc <= 2'd0;
        else     m_presc <= m_presc + 2'd1;
    end
    wire m_tick = (m_presc == 2'd3);

    // Observations of one service, filled by observe().
    int         obs_pulses, obs_done, obs_gap_cyc, obs_gap_ticks;
    int         obs_first, obs_gchg, obs_timeout;
    logic [3:0] obs_grant, obs_after_grant;
    logic       obs_after_busy;
    int         obs_hlen[$];
    int         obs_hticks[$];
    int         obs_olen[$];

    task automatic observe(input int max_cyc, input logic [3:0] drop,
                           input logic [11:0] cnt_after, input bit change_cnt);
        int hl = 0, ht = 0, low_run = 0, low_ticks = 0;
        bit prev_led = 0, got = 0;
        obs_pulses = 0; obs_done = 0; obs_gap_cyc = 0; obs_gap_ticks = 0;
        obs_first = -1; obs_gchg = 0; obs_timeout = 1;
        obs_grant = 4'd0; obs_after_grant = 4'hf; obs_after_busy = 1'b1;
        obs_hlen.delete(); obs_hticks.delete(); obs_olen.delete();
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            if (grant != 4'd0 && !got) begin
                got = 1; obs_grant = grant; obs_first = c;
                req = req & ~drop;
                if (change_cnt) req_cnt = cnt_after;
            end else if (got && grant != obs_grant) begin
                obs_gchg++;
            end
            if (led) begin
                if (!prev_led) begin
                    if (obs_pulses > 0) obs_olen.push_back(low_run);
                    obs_pulses++; hl = 0; ht = 0;
                end
                hl++;
                if (m_tick) ht++;
                low_run = 0; low_ticks = 0;
            end else if (got) begin
                if (prev_led) begin
                    obs_hlen.push_back(hl); obs_hticks.push_back(ht);
                end
                low_run++;
                if (m_tick) low_ticks++;
            end
            prev_led = led;
            if (done) begin
                obs_done++;
                obs_gap_cyc = low_run; obs_gap_ticks = low_ticks;
                @(negedge clk);
                obs_after_grant = grant; obs_after_busy = busy;
                if (done) obs_done++;
                obs_timeout = 0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int bad_idle = 0, bad_flg = 0, flg_cnt = 0;
        logic prev_tick;
        rst = 1'b1; req = 4'd0; req_cnt = 12'd0;
        repeat (3) @(negedge clk);
        checks++;
        if ({grant, done, led, busy, flg} !== 8'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 00000000", {grant, done, led, busy, flg});
        end
        rst = 1'b0;
        prev_tick = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ({grant, led, busy, done} !== 7'd0) bad_idle++;
            if (flg !== prev_tick) bad_flg++;
            if (flg) flg_cnt++;
            prev_tick = m_tick;
        end
        $display("test_reset: idle_bad=%0d flg_bad=%0d flg_pulses=%0d", bad_idle, bad_flg, flg_cnt);
        checks++;
        if (bad_idle !== 0) begin errors++; $display("FAIL idle_quiet: got %0d bad cycles expected 0", bad_idle); end
        checks++;
        if (bad_flg !== 0) begin errors++; $display("FAIL flg_timing: got %0d bad cycles expected 0", bad_flg); end
        checks++;
        if (flg_cnt !== 5) begin errors++; $display("FAIL flg_count: got %0d expected 5", flg_cnt); end
    endtask

    task automatic test_single();
        req_cnt = 12'd3; req = 4'b0001;
        observe(300, 4'b0001, 12'd0, 1'b0);
        $display("test_single: grant=%b pulses=%0d done=%0d gap_cyc=%0d gap_ticks=%0d",
                 obs_grant, obs_pulses, obs_done, obs_gap_cyc, obs_gap_ticks);
        checks++;
        if (obs_timeout !== 0) begin errors++; $display("FAIL single_timeout: got %0d expected 0", obs_timeout); end
        checks++;
        if (obs_first !== 0) begin errors++; $display("FAIL single_latency: got %0d expected 0", obs_first); end
        checks++;
        if (obs_grant !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b expected 0001", obs_grant); end
        checks++;
        if (obs_pulses !== 3) begin errors++; $display("FAIL single_pulses: got %0d expected 3", obs_pulses); end
        foreach (obs_hticks[i]) begin
            checks++;
            if (obs_hticks[i] !== 2) begin errors++; $display("FAIL single_on_ticks: got %0d expected 2", obs_hticks[i]); end
        end
        for (int i = 1; i < obs_hlen.size(); i++) begin
            checks++;
            if (obs_hlen[i] !== 8) begin errors++; $display("FAIL single_on_len: got %0d expected 8", obs_hlen[i]); end
        end
        foreach (obs_olen[i]) begin
            checks++;
            if (obs_olen[i] !== 8) begin errors++; $display("FAIL single_off_len: got %0d expected 8", obs_olen[i]); end
        end
        checks++;
        if (obs_gap_cyc !== 16) begin errors++; $display("FAIL single_gap_cyc: got %0d expected 16", obs_gap_cyc); end
        checks++;
        if (obs_gap_ticks !== 4) begin errors++; $display("FAIL single_gap_ticks: got %0d expected 4", obs_gap_ticks); end
        checks++;
        if (obs_done !== 1) begin errors++; $display("FAIL single_done: got %0d expected 1", obs_done); end
        checks++;
        if (obs_gchg !== 0) begin errors++; $display("FAIL single_grant_stable: got %0d changes expected 0", obs_gchg); end
        checks++;
        if ({obs_after_grant, obs_after_busy} !== 5'd0) begin
            errors++;
            $display("FAIL single_after: got grant=%b busy=%b expected 0000/0", obs_after_grant, obs_after_busy);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g [5];
        exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
        exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        req_cnt = {3'd1, 3'd1, 3'd1, 3'd1}; req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            observe(200, 4'b0000, 12'd0, 1'b0);
            if (i == 4) req = 4'b0000;
            $display("test_round_robin: svc=%0d grant=%b pulses=%0d done=%0d", i, obs_grant, obs_pulses, obs_done);
            checks++;
            if (obs_grant !== exp_g[i]) begin errors++; $display("FAIL rr_grant[%0d]: got %b expected %b", i, obs_grant, exp_g[i]); end
            checks++;
            if (obs_pulses !== 1) begin errors++; $display("FAIL rr_pulses[%0d]: got %0d expected 1", i, obs_pulses); end
            checks++;
            if (obs_done !== 1) begin errors++; $display("FAIL rr_done[%0d]: got %0d expected 1", i, obs_done); end
            checks++;
            if (obs_after_grant !== 4'd0) begin errors++; $display("FAIL rr_after[%0d]: got %b expected 0000", i, obs_after_grant); end
        end
    endtask

    task automatic test_zero_count();
        req_cnt = 12'd0; req = 4'b0100;
        observe(200, 4'b0100, 12'd0, 1'b0);
        $display("test_zero_count: grant=%b pulses=%0d gap_ticks=%0d done=%0d",
                 obs_grant, obs_pulses, obs_gap_ticks, obs_done);
        checks++;
        if (obs_grant !== 4'b0100) begin errors++; $display("FAIL zero_grant: got %b expected 0100", obs_grant); end
        checks++;
        if (obs_pulses !== 0) begin errors++; $display("FAIL zero_pulses: got %0d expected 0", obs_pulses); end
        checks++;
        if (obs_gap_ticks !== 4) begin errors++; $display("FAIL zero_gap_ticks: got %0d expected 4", obs_gap_ticks); end
        checks++;
        if (obs_done !== 1) begin errors++; $display("FAIL zero_done: got %0d expected 1", obs_done); end
        checks++;
        if (obs_after_grant !== 4'd0) begin errors++; $display("FAIL zero_after: got %b expected 0000", obs_after_grant); end
    endtask

    task automatic test_latch();
        req_cnt = 12'b000_000_010_000; req = 4'b0010;
        observe(300, 4'b0010, 12'b000_000_111_000, 1'b1);
        $display("test_latch: grant=%b pulses=%0d done=%0d", obs_grant, obs_pulses, obs_done);
        checks++;
        if (obs_grant !== 4'b0010) begin errors++; $display("FAIL latch_grant: got %b expected 0010", obs_grant); end
        checks++;
        if (obs_pulses !== 2) begin errors++; $display("FAIL latch_pulses: got %0d expected 2", obs_pulses); end
        checks++;
        if (obs_done !== 1) begin errors++; $display("FAIL latch_done: got %0d expected 1", obs_done); end
        checks++;
        if (obs_gchg !== 0) begin errors++; $display("FAIL latch_grant_stable: got %0d changes expected 0", obs_gchg); end
    endtask

    task automatic test_reset_mid();
        int rises = 0, done_seen = 0;
        bit prev_led = 0, reached = 0;
        req_cnt = 12'd5 << 6; req = 4'b0100;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (grant != 4'd0) req = 4'b0000;
            if (done) done_seen++;
            if (led && !prev_led) rises++;
            prev_led = led;
            if (rises == 2) begin reached = 1; break; end
        end
        checks++;
        if (reached !== 1'b1) begin errors++; $display("FAIL mid_second_blink: got %0d blinks expected 2", rises); end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        $display("test_reset_mid: in_reset led=%b grant=%b busy=%b done=%b", led, grant, busy, done);
        checks++;
        if ({led, grant, busy, done, flg} !== 8'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got %b expected 00000000", {led, grant, busy, done, flg});
        end
        repeat (2) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        checks++;
        if (done_seen !== 0) begin errors++; $display("FAIL mid_no_done: got %0d expected 0", done_seen); end
        rst = 1'b0;
        req_cnt = 12'b000_000_001_000; req = 4'b1010;
        observe(200, 4'b1010, 12'd0, 1'b0);
        $display("test_reset_mid: after_release grant=%b done=%0d", obs_grant, obs_done);
        checks++;
        if (obs_grant !== 4'b0010) begin errors++; $display("FAIL mid_regrant: got %b expected 0010", obs_grant); end
        checks++;
        if (obs_done !== 1) begin errors++; $display("FAIL mid_regrant_done: got %0d expected 1", obs_done); end
    endtask

    initial begin
        rst = 1'b1; req = 4'd0; req_cnt = 12'd0;
        test_reset();
        test_single();
        test_round_robin();
        test_zero_count();
        test_latch();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
